// File: rtl/pc_pipe_gen.sv
// pc_pipe_gen: fetch PC generator carrying each fetched PC through a valid-tagged stage pipeline
module pc_pipe_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h2000,
  parameter int INST_BYTES = 4,
  parameter int STAGES = 3,
  parameter int REDIR_STAGE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   redirect_ready,
  input  logic                   trap_valid,
  input  logic [XLEN-1:0]        trap_pc,
  output logic [XLEN-1:0]        pc_f,
  output logic [STAGES*XLEN-1:0] pc_stage,
  output logic [STAGES-1:0]      valid_stage,
  output logic                   misalign_err,
  output logic [XLEN-1:0]        misalign_pc
);
  localparam logic [XLEN-1:0] low_mask = XLEN'(INST_BYTES - 1);
  logic [STAGES-1:0][XLEN-1:0] pcs, sh_pc;
  logic [STAGES-1:0] sh_v, flush;
  logic acc, mis;
  assign redirect_ready = !reset && !stall && !trap_valid;
  assign acc = redirect_valid && redirect_ready;
  assign mis = acc && |(redirect_pc & low_mask);
  assign pc_stage = pcs;
  always_comb begin
    sh_pc = pcs;
    sh_v = valid_stage;
    flush = '0;
    sh_pc[0] = pc_f;
    sh_v[0] = 1'b1;
    for (int i = 1; i < STAGES; i++) begin
      sh_pc[i] = pcs[i-1];
      sh_v[i] = valid_stage[i-1];
    end
    for (int i = 0; i < STAGES; i++) flush[i] = i < REDIR_STAGE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f <= RESET_PC;
      pcs <= '0;
      valid_stage <= '0;
      misalign_err <= 1'b0;
      misalign_pc <= '0;
    end else begin
      misalign_err <= mis;
      if (mis) misalign_pc <= redirect_pc;
      if (trap_valid) begin
        pc_f <= trap_pc & ~low_mask;
        valid_stage <= '0;
      end else if (acc) begin
        pc_f <= mis ? pc_f : redirect_pc;
        pcs <= sh_pc;
        valid_stage <= sh_v & ~flush;
      end else if (!stall) begin
        pc_f <= pc_f + XLEN'(INST_BYTES);
        pcs <= sh_pc;
        valid_stage <= sh_v;
      end
    end
  end
endmodule

// File: tb/tb_pc_pipe_gen.sv
// tb_pc_pipe_gen: directed and random stimulus against a queue-based reference model
module tb_pc_pipe_gen;
  localparam int XLEN = 32, STAGES = 3, RS = 1, IB = 4;
  localparam logic [31:0] RPC = 32'h2000;
  logic clk = 0, reset = 1, stall = 0, redirect_valid = 0, trap_valid = 0;
  logic [31:0] redirect_pc = '0, trap_pc = '0;
  logic redirect_ready, misalign_err;
  logic [31:0] pc_f, misalign_pc;
  logic [STAGES*XLEN-1:0] pc_stage;
  logic [STAGES-1:0] valid_stage;
  int cmp = 0, bad = 0;
  bit chk_en = 0;
  typedef struct {logic [31:0] pc; bit v;} ent_t;
  ent_t q[$];
  logic [31:0] m_pc, m_mpc;
  bit m_err;

  pc_pipe_gen #(.XLEN(XLEN), .RESET_PC(RPC), .INST_BYTES(IB), .STAGES(STAGES), .REDIR_STAGE(RS)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .trap_valid(trap_valid), .trap_pc(trap_pc), .pc_f(pc_f),
    .pc_stage(pc_stage), .valid_stage(valid_stage), .misalign_err(misalign_err), .misalign_pc(misalign_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Reference: stages are a queue of fetched PCs, youngest at the front
  task automatic model_step();
    bit acc, mis;
    ent_t e;
    if (reset) begin
      m_pc = RPC; m_err = 0; m_mpc = 0;
      q.delete();
      e.pc = 0; e.v = 0;
      repeat (STAGES) q.push_back(e);
    end else begin
      acc = redirect_valid && !stall && !trap_valid;
      mis = acc && (redirect_pc % IB != 0);
      m_err = mis;
      if (mis) m_mpc = redirect_pc;
      if (trap_valid) begin
        m_pc = trap_pc - trap_pc % IB;
        foreach (q[i]) q[i].v = 0;
      end else if (acc || !stall) begin
        e.pc = m_pc; e.v = 1;
        q.push_front(e);
        void'(q.pop_back());
        if (acc) for (int i = 0; i < RS; i++) q[i].v = 0;
        m_pc = !acc ? m_pc + 32'(IB) : mis ? m_pc : redirect_pc;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_f", pc_f, m_pc);
      for (int i = 0; i < STAGES; i++) begin
        chk($sformatf("pc_stage[%0d]", i), pc_stage[i*XLEN +: XLEN], q[i].pc);
        chk($sformatf("valid_stage[%0d]", i), valid_stage[i], q[i].v);
      end
      chk("misalign_err", misalign_err, m_err);
      chk("misalign_pc", misalign_pc, m_mpc);
      chk("redirect_ready", redirect_ready, !reset && !stall && !trap_valid);
    end
  end

  initial begin
    logic [31:0] r;
    bit hold;
    step(2);
    chk_en = 1;
    chk("rst_pc_f", pc_f, 32'h2000);
    chk("rst_valid", valid_stage, 0);
    chk("rst_stages", pc_stage, 0);
    chk("rst_ready", redirect_ready, 0);
    reset = 0;
    step(1);
    chk("seq1_pc_f", pc_f, 32'h2004);
    chk("seq1_valid", valid_stage, 3'b001);
    chk("seq1_stage0", pc_stage[31:0], 32'h2000);
    step(1);
    chk("seq2_pc_f", pc_f, 32'h2008);
    chk("seq2_valid", valid_stage, 3'b011);
    stall = 1; redirect_valid = 1; redirect_pc = 32'h3000;
    #1 chk("stall_ready", redirect_ready, 0);
    step(3);
    chk("stall_pc_f", pc_f, 32'h2008);
    chk("stall_valid", valid_stage, 3'b011);
    chk("stall_stage0", pc_stage[31:0], 32'h2004);
    stall = 0;
    #1 chk("unstall_ready", redirect_ready, 1);
    step(1);
    chk("redir_pc_f", pc_f, 32'h3000);
    chk("redir_valid", valid_stage, 3'b110);
    chk("redir_stage1", pc_stage[63:32], 32'h2004);
    redirect_pc = 32'h3002;
    step(1);
    redirect_valid = 0;
    chk("mis_pc_f", pc_f, 32'h3000);
    chk("mis_valid", valid_stage, 3'b100);
    chk("mis_err", misalign_err, 1);
    chk("mis_pc", misalign_pc, 32'h3002);
    step(1);
    chk("mis_err_fall", misalign_err, 0);
    chk("mis_pc_hold", misalign_pc, 32'h3002);
    chk("post_mis_pc_f", pc_f, 32'h3004);
    stall = 1; redirect_valid = 1; redirect_pc = 32'h4000; trap_valid = 1; trap_pc = 32'h1003;
    #1 chk("trap_ready", redirect_ready, 0);
    step(1);
    chk("trap_pc_f", pc_f, 32'h1000);
    chk("trap_valid_clr", valid_stage, 0);
    chk("trap_stage0_hold", pc_stage[31:0], 32'h3000);
    trap_valid = 0; stall = 0; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 0;
    chk("wrap_setup", pc_f, 32'hFFFF_FFFC);
    step(1);
    chk("wrap_pc_f", pc_f, 32'h0);
    redirect_valid = 1; redirect_pc = 32'h5000; reset = 1;
    step(1);
    chk("rst2_pc_f", pc_f, 32'h2000);
    chk("rst2_valid", valid_stage, 0);
    chk("rst2_stages", pc_stage, 0);
    chk("rst2_mis_pc", misalign_pc, 0);
    reset = 0; redirect_valid = 0;
    for (int n = 0; n < 3000; n++) begin
      hold = redirect_valid && (reset || stall || trap_valid);
      reset = ($urandom_range(63) == 0);
      trap_valid = ($urandom_range(15) == 0);
      trap_pc = $urandom;
      stall = ($urandom_range(3) == 0);
      if (!hold) begin
        redirect_valid = ($urandom_range(3) == 0);
        r = $urandom;
        if ($urandom_range(15) == 0) r[31:4] = '1;
        redirect_pc = ($urandom_range(3) == 0) ? r : r & ~32'h3;
      end
      step(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
